// File: rtl/dds_write_sequencer_if.sv
// Command push port of the DDS write sequencer: one queued register write per valid/ready beat.
interface dds_write_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_instr;
    logic [31:0] cmd_data;
    logic [2:0]  cmd_nbytes;

    modport master (output cmd_valid, cmd_instr, cmd_data, cmd_nbytes, input cmd_ready);
    modport slave  (input cmd_valid, cmd_instr, cmd_data, cmd_nbytes, output cmd_ready);
endinterface

// File: rtl/dds_write_sequencer.sv
// Queues DDS register writes and plays them out as one serial burst (sclk/sdio/cs_n)
// per external trigger, closing the burst with an io_update pulse and a one-cycle flag.
module dds_write_sequencer #(
    parameter int unsigned SCLK_HALF   = 3,
    parameter int unsigned CS_GAP      = 2,
    parameter int unsigned IOUP_CYCLES = 4,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                        FiftyMHz_int_ref_clock,
    input  logic                        reset,
    input  logic                        trigger,
    dds_write_sequencer_if.slave        cmd,
    input  logic                        clear_overrun,
    output logic                        sclk,
    output logic                        sdio,
    output logic                        cs_n,
    output logic                        io_update,
    output logic                        busy,
    output logic                        flag,
    output logic                        overrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTW    = AW + 1;
    localparam int unsigned GAP_CYC = CS_GAP * 2 * SCLK_HALF;
    localparam int unsigned MAX_A   = (GAP_CYC > IOUP_CYCLES) ? GAP_CYC : IOUP_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_A > SCLK_HALF) ? MAX_A : SCLK_HALF;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, GAP, UPDATE, DONE} state_e;

    typedef struct packed {
        logic [2:0]  nbytes;
        logic [7:0]  instr;
        logic [31:0] data;
    } entry_t;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [39:0]     shreg_q, shreg_d;
    logic [5:0]      bitcnt_q, bitcnt_d;
    logic            sclk_q, sclk_d;
    logic            overrun_q, overrun_d;
    logic            trig_s1_q, trig_s2_q, trig_s3_q, trig_edge;
    entry_t          mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0] count_q;
    entry_t          push_entry, head;
    logic            push, pop;
    logic [39:0]     load_word;
    logic [5:0]      load_bits;

    // Trigger pin is asynchronous: two flops to synchronise, a third for edge detection.
    always_ff @(posedge FiftyMHz_int_ref_clock) begin
        if (reset) begin
            trig_s1_q <= 1'b0;
            trig_s2_q <= 1'b0;
            trig_s3_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            trig_s1_q <= trigger;
            trig_s2_q <= trig_s1_q;
            trig_s3_q <= trig_s2_q;
            overrun_q <= overrun_d;
        end
    end

    assign trig_edge = trig_s2_q & ~trig_s3_q;

    always_comb begin
        overrun_d = overrun_q;
        if (clear_overrun) overrun_d = 1'b0;
        if (trig_edge && state_q != IDLE) overrun_d = 1'b1;
    end

    assign cmd.cmd_ready = (count_q != CNTW'(FIFO_DEPTH));
    assign push          = cmd.cmd_valid & cmd.cmd_ready;
    assign push_entry    = '{nbytes: (cmd.cmd_nbytes > 3'd4) ? 3'd4 : cmd.cmd_nbytes,
                             instr:  cmd.cmd_instr,
                             data:   cmd.cmd_data};
    assign head          = mem_q[rd_ptr_q];

    always_ff @(posedge FiftyMHz_int_ref_clock) begin
        if (push) mem_q[wr_ptr_q] <= push_entry;
    end

    always_ff @(posedge FiftyMHz_int_ref_clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    // Data bytes are left-aligned behind the instruction so shifting out of bit 39 is MSB first.
    always_comb begin
        case (head.nbytes)
            3'd0:    load_word = {head.instr, 32'h0};
            3'd1:    load_word = {head.instr, head.data[7:0], 24'h0};
            3'd2:    load_word = {head.instr, head.data[15:0], 16'h0};
            3'd3:    load_word = {head.instr, head.data[23:0], 8'h0};
            default: load_word = {head.instr, head.data};
        endcase
        load_bits = 6'd8 + {head.nbytes, 3'b000};
    end

    always_ff @(posedge FiftyMHz_int_ref_clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            sclk_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            sclk_q   <= sclk_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        sclk_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (trig_edge && count_q != '0) state_d = LOAD;
            end
            LOAD: begin
                shreg_d  = load_word;
                bitcnt_d = load_bits;
                cnt_d    = '0;
                state_d  = SHIFT;
            end
            SHIFT: begin
                sclk_d = sclk_q;
                if (cnt_q == CW'(SCLK_HALF - 1)) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        // Clearing the shifter on the last bit returns sdio low for the gap.
                        if (bitcnt_q == 6'd1) begin
                            shreg_d = '0;
                            state_d = GAP;
                        end else begin
                            bitcnt_d = bitcnt_q - 6'd1;
                            shreg_d  = {shreg_q[38:0], 1'b0};
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == CW'(GAP_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = (count_q != '0) ? LOAD : UPDATE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            UPDATE: begin
                if (cnt_q == CW'(IOUP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop       = (state_q == LOAD);
        cs_n      = !(state_q == LOAD || state_q == SHIFT);
        io_update = (state_q == UPDATE);
        flag      = (state_q == DONE);
        busy      = !(state_q == IDLE || state_q == DONE);
    end

    assign sclk       = sclk_q;
    assign sdio       = shreg_q[39];
    assign overrun    = overrun_q;
    assign fifo_count = count_q;
endmodule
